// File: rtl/apb_fsm_controller.sv
// APB-side sequencer of the AHB-to-APB bridge: turns pipelined AHB beats into APB SETUP/ENABLE phases.
// Optional macro APB_PREADY_EN adds a Pready input that can stretch ENABLE phases.
module apb_fsm_controller #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  Hclk,
    input  logic                  Hresetn,
    input  logic                  valid,
    input  logic [ADDR_WIDTH-1:0] Haddr,
    input  logic [ADDR_WIDTH-1:0] Haddr1,
    input  logic [ADDR_WIDTH-1:0] Haddr2,
    input  logic [DATA_WIDTH-1:0] Hwdata,
    input  logic                  Hwrite,
    input  logic                  Hwritereg,
    input  logic [2:0]            tempselx,
`ifdef APB_PREADY_EN
    input  logic                  Pready,
`endif
    output logic [2:0]            Pselx,
    output logic                  Penable,
    output logic                  Pwrite,
    output logic [ADDR_WIDTH-1:0] Paddr,
    output logic [DATA_WIDTH-1:0] Pwdata,
    output logic                  Hreadyout
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WWAIT,
        ST_READ,
        ST_WRITE,
        ST_WRITEP,
        ST_RENABLE,
        ST_WENABLE,
        ST_WENABLEP
    } state_t;

    state_t                  state, state_nxt;
    logic [2:0]              selx1, selx2;
    logic [2:0]              pselx_nxt;
    logic                    penable_nxt;
    logic                    pwrite_nxt;
    logic [ADDR_WIDTH-1:0]   paddr_nxt;
    logic [DATA_WIDTH-1:0]   pwdata_nxt;
    logic                    hready_nxt;
    logic                    pready_int;

`ifdef APB_PREADY_EN
    assign pready_int = Pready;
`else
    assign pready_int = 1'b1;
`endif

    // State, select delay line and registered APB/AHB outputs
    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            state     <= ST_IDLE;
            selx1     <= '0;
            selx2     <= '0;
            Pselx     <= '0;
            Penable   <= 1'b0;
            Pwrite    <= 1'b0;
            Paddr     <= '0;
            Pwdata    <= '0;
            Hreadyout <= 1'b1;
        end else begin
            state     <= state_nxt;
            selx1     <= tempselx;
            selx2     <= selx1;
            Pselx     <= pselx_nxt;
            Penable   <= penable_nxt;
            Pwrite    <= pwrite_nxt;
            Paddr     <= paddr_nxt;
            Pwdata    <= pwdata_nxt;
            Hreadyout <= hready_nxt;
        end
    end

    // Next state and next output values; anything not assigned holds
    always_comb begin
        state_nxt   = state;
        pselx_nxt   = Pselx;
        penable_nxt = Penable;
        pwrite_nxt  = Pwrite;
        paddr_nxt   = Paddr;
        pwdata_nxt  = Pwdata;
        hready_nxt  = Hreadyout;

        case (state)
            ST_IDLE: begin
                if (valid && !Hwrite) begin
                    state_nxt   = ST_READ;
                    paddr_nxt   = Haddr;
                    pselx_nxt   = tempselx;
                    pwrite_nxt  = 1'b0;
                    penable_nxt = 1'b0;
                    hready_nxt  = 1'b0;
                end else begin
                    if (valid) begin
                        state_nxt = ST_WWAIT;
                    end
                    pselx_nxt   = '0;
                    penable_nxt = 1'b0;
                    hready_nxt  = 1'b1;
                end
            end

            // Write data arrives one cycle after its address: issue SETUP from the delayed copy
            ST_WWAIT: begin
                paddr_nxt   = Haddr1;
                pwdata_nxt  = Hwdata;
                pselx_nxt   = selx1;
                pwrite_nxt  = 1'b1;
                penable_nxt = 1'b0;
                state_nxt   = valid ? ST_WRITEP : ST_WRITE;
                hready_nxt  = !valid;
            end

            ST_READ: begin
                state_nxt   = ST_RENABLE;
                penable_nxt = 1'b1;
                hready_nxt  = 1'b1;
            end

            ST_WRITE: begin
                state_nxt   = valid ? ST_WENABLEP : ST_WENABLE;
                penable_nxt = 1'b1;
                hready_nxt  = 1'b1;
            end

            ST_WRITEP: begin
                state_nxt   = ST_WENABLEP;
                penable_nxt = 1'b1;
                hready_nxt  = 1'b1;
            end

            ST_RENABLE, ST_WENABLE: begin
                if (!pready_int) begin
                    hready_nxt = 1'b0;
                end else if (valid && !Hwrite) begin
                    state_nxt   = ST_READ;
                    paddr_nxt   = Haddr;
                    pselx_nxt   = tempselx;
                    pwrite_nxt  = 1'b0;
                    penable_nxt = 1'b0;
                    hready_nxt  = 1'b0;
                end else if (valid) begin
                    state_nxt   = ST_WWAIT;
                    pselx_nxt   = '0;
                    penable_nxt = 1'b0;
                end else begin
                    state_nxt   = ST_IDLE;
                    pselx_nxt   = '0;
                    penable_nxt = 1'b0;
                    hready_nxt  = 1'b1;
                end
            end

            // A pipelined beat is pending; its address sits two (write) or one (read) stages back
            ST_WENABLEP: begin
                if (!pready_int) begin
                    hready_nxt = 1'b0;
                end else if (Hwritereg) begin
                    state_nxt   = valid ? ST_WRITEP : ST_WRITE;
                    paddr_nxt   = Haddr2;
                    pselx_nxt   = selx2;
                    pwdata_nxt  = Hwdata;
                    pwrite_nxt  = 1'b1;
                    penable_nxt = 1'b0;
                    hready_nxt  = !valid;
                end else begin
                    state_nxt   = ST_READ;
                    paddr_nxt   = Haddr1;
                    pselx_nxt   = selx1;
                    pwrite_nxt  = 1'b0;
                    penable_nxt = 1'b0;
                    hready_nxt  = 1'b0;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Bench for apb_fsm_controller: directed vector table, reset/Pready sequences, and random traffic
// against a rule-table reference model.
module tb_apb_fsm_controller;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
`ifdef APB_PREADY_EN
    localparam bit HAS_READY = 1'b1;
`else
    localparam bit HAS_READY = 1'b0;
`endif

    logic          hclk = 1'b0;
    logic          hresetn = 1'b0;
    logic          valid = 1'b0;
    logic          hwrite = 1'b0;
    logic          pready = 1'b1;
    logic [AW-1:0] haddr = '0;
    logic [AW-1:0] haddr1 = '0;
    logic [AW-1:0] haddr2 = '0;
    logic [DW-1:0] hwdata = '0;
    logic          hwritereg = 1'b0;
    logic [2:0]    tempselx;
    logic [2:0]    pselx;
    logic          penable, pwrite, hreadyout;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;

    int n_checks = 0;
    int n_err    = 0;

    always #5 hclk = ~hclk;

    // AHB-slave style pipeline copies of the address phase
    always @(posedge hclk) begin
        haddr1    <= haddr;
        haddr2    <= haddr1;
        hwritereg <= hwrite;
    end

    function automatic logic [2:0] decode(input logic [AW-1:0] a);
        case (a[31:26])
            6'h20:   return 3'b001;
            6'h21:   return 3'b010;
            6'h22:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    assign tempselx = decode(haddr);

    apb_fsm_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .Hclk(hclk), .Hresetn(hresetn), .valid(valid),
        .Haddr(haddr), .Haddr1(haddr1), .Haddr2(haddr2), .Hwdata(hwdata),
        .Hwrite(hwrite), .Hwritereg(hwritereg), .tempselx(tempselx),
`ifdef APB_PREADY_EN
        .Pready(pready),
`endif
        .Pselx(pselx), .Penable(penable), .Pwrite(pwrite),
        .Paddr(paddr), .Pwdata(pwdata), .Hreadyout(hreadyout)
    );

    typedef struct packed {
        logic [2:0]    psel;
        logic          pen;
        logic          pwrite;
        logic [AW-1:0] paddr;
        logic [DW-1:0] pwdata;
        logic          hready;
    } out_t;

    typedef struct packed {
        logic          rst_n;
        logic          valid;
        logic          hwrite;
        logic [AW-1:0] haddr;
        logic [DW-1:0] hwdata;
        out_t          exp;
    } vec_t;

    // ---------------- reference model: first-match rule table ----------------
    typedef enum int {PH_IDLE, PH_WWAIT, PH_READ, PH_WRITE, PH_WRITEP,
                      PH_RENABLE, PH_WENABLE, PH_WENABLEP} phase_t;
    localparam int DC = -1, HOLD = 0, CUR = 1, D1 = 2, D2 = 3, ZERO = 4;

    typedef struct {
        phase_t from;
        int     v, w, wr;
        phase_t to;
        int     asrc, ssrc;
        bit     dld;
        int     pw;
        bit     pen;
        int     hr;
    } rule_t;

    rule_t      rules[$];
    phase_t     m_ph = PH_IDLE;
    out_t       m_out = '0;
    logic [2:0] m_sel1 = '0, m_sel2 = '0;

    function automatic void add(phase_t f, int v, int w, int wr, phase_t t, int as, int ss,
                                bit dl, int pw, bit pe, int hr);
        rule_t r;
        r.from = f; r.v = v; r.w = w; r.wr = wr; r.to = t; r.asrc = as; r.ssrc = ss;
        r.dld = dl; r.pw = pw; r.pen = pe; r.hr = hr;
        rules.push_back(r);
    endfunction

    function automatic void init_rules();
        add(PH_IDLE,     1,  0,  DC, PH_READ,     CUR,  CUR,  0, 0,  0, 0);
        add(PH_IDLE,     1,  1,  DC, PH_WWAIT,    HOLD, ZERO, 0, DC, 0, 1);
        add(PH_IDLE,     DC, DC, DC, PH_IDLE,     HOLD, ZERO, 0, DC, 0, 1);
        add(PH_WWAIT,    1,  DC, DC, PH_WRITEP,   D1,   D1,   1, 1,  0, 0);
        add(PH_WWAIT,    0,  DC, DC, PH_WRITE,    D1,   D1,   1, 1,  0, 1);
        add(PH_READ,     DC, DC, DC, PH_RENABLE,  HOLD, HOLD, 0, DC, 1, 1);
        add(PH_WRITE,    1,  DC, DC, PH_WENABLEP, HOLD, HOLD, 0, DC, 1, 1);
        add(PH_WRITE,    0,  DC, DC, PH_WENABLE,  HOLD, HOLD, 0, DC, 1, 1);
        add(PH_WRITEP,   DC, DC, DC, PH_WENABLEP, HOLD, HOLD, 0, DC, 1, 1);
        for (int k = 0; k < 2; k++) begin
            phase_t p;
            p = (k == 0) ? PH_RENABLE : PH_WENABLE;
            add(p, 1,  0,  DC, PH_READ,  CUR,  CUR,  0, 0,  0, 0);
            add(p, 1,  1,  DC, PH_WWAIT, HOLD, ZERO, 0, DC, 0, DC);
            add(p, DC, DC, DC, PH_IDLE,  HOLD, ZERO, 0, DC, 0, 1);
        end
        add(PH_WENABLEP, 1,  DC, 1,  PH_WRITEP,   D2,   D2,   1, 1,  0, 0);
        add(PH_WENABLEP, 0,  DC, 1,  PH_WRITE,    D2,   D2,   1, 1,  0, 1);
        add(PH_WENABLEP, DC, DC, 0,  PH_READ,     D1,   D1,   0, 0,  0, 0);
    endfunction

    function automatic bit ok(int pat, logic b);
        return (pat == DC) || (pat == int'(b));
    endfunction

    function automatic void model_step(input logic rst, v, w, wr, rdy,
                                       input logic [AW-1:0] a0, a1, a2,
                                       input logic [DW-1:0] d, input logic [2:0] s0);
        logic [2:0] s1, s2;
        bit hit;
        s1 = m_sel1;
        s2 = m_sel2;
        if (!rst) begin
            m_sel1 = '0; m_sel2 = '0; m_ph = PH_IDLE;
            m_out = '0; m_out.hready = 1'b1;
            return;
        end
        m_sel2 = s1;
        m_sel1 = s0;
        if ((m_ph == PH_RENABLE || m_ph == PH_WENABLE || m_ph == PH_WENABLEP) && !rdy) begin
            m_out.hready = 1'b0;
            return;
        end
        hit = 1'b0;
        foreach (rules[i]) begin
            if (!hit && rules[i].from == m_ph && ok(rules[i].v, v) && ok(rules[i].w, w)
                && ok(rules[i].wr, wr)) begin
                hit = 1'b1;
                case (rules[i].asrc)
                    CUR:     m_out.paddr = a0;
                    D1:      m_out.paddr = a1;
                    D2:      m_out.paddr = a2;
                    default: ;
                endcase
                case (rules[i].ssrc)
                    CUR:     m_out.psel = s0;
                    D1:      m_out.psel = s1;
                    D2:      m_out.psel = s2;
                    ZERO:    m_out.psel = '0;
                    default: ;
                endcase
                if (rules[i].dld) m_out.pwdata = d;
                if (rules[i].pw != DC) m_out.pwrite = (rules[i].pw == 1);
                m_out.pen = rules[i].pen;
                if (rules[i].hr != DC) m_out.hready = (rules[i].hr == 1);
                m_ph = rules[i].to;
            end
        end
    endfunction

    // ---------------- stimulus / checking helpers ----------------
    function automatic out_t dut_out();
        out_t o;
        o.psel = pselx; o.pen = penable; o.pwrite = pwrite;
        o.paddr = paddr; o.pwdata = pwdata; o.hready = hreadyout;
        return o;
    endfunction

    function automatic out_t mk(input logic [2:0] ps, input logic pe, pw,
                                input logic [AW-1:0] pa, input logic [DW-1:0] pd, input logic hr);
        out_t o;
        o.psel = ps; o.pen = pe; o.pwrite = pw; o.paddr = pa; o.pwdata = pd; o.hready = hr;
        return o;
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("psel=%b pen=%b pwr=%b paddr=%h pwdata=%h hready=%b",
                         o.psel, o.pen, o.pwrite, o.paddr, o.pwdata, o.hready);
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic tick(input logic r, v, w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic rdy);
        hresetn = r; valid = v; hwrite = w; haddr = a; hwdata = d; pready = rdy;
        model_step(r, v, w, hwritereg, HAS_READY ? rdy : 1'b1, a, haddr1, haddr2, d, decode(a));
        @(posedge hclk);
        #1;
    endtask

    vec_t vecs[$];

    function automatic void vec(input logic r, v, w, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input out_t e);
        vec_t x;
        x.rst_n = r; x.valid = v; x.hwrite = w; x.haddr = a; x.hwdata = d; x.exp = e;
        vecs.push_back(x);
    endfunction

    initial begin
        out_t       prev;
        logic [AW-1:0] a;
        init_rules();

        // reset, single read, single write, back-to-back writes, write->read, read/write mixes
        vec(0, 0, 0, 32'h0,         32'h0,        mk(3'b000, 0, 0, 32'h0,         32'h0,        1));
        vec(0, 0, 0, 32'h0,         32'h0,        mk(3'b000, 0, 0, 32'h0,         32'h0,        1));
        vec(1, 1, 0, 32'h8000_0010, 32'h0,        mk(3'b001, 0, 0, 32'h8000_0010, 32'h0,        0));
        vec(1, 0, 0, 32'h8000_0010, 32'h0,        mk(3'b001, 1, 0, 32'h8000_0010, 32'h0,        1));
        vec(1, 0, 0, 32'h8000_0010, 32'h0,        mk(3'b000, 0, 0, 32'h8000_0010, 32'h0,        1));
        vec(1, 1, 1, 32'h8400_0004, 32'h0,        mk(3'b000, 0, 0, 32'h8000_0010, 32'h0,        1));
        vec(1, 0, 1, 32'h8400_0004, 32'hDEAD_BEEF, mk(3'b010, 0, 1, 32'h8400_0004, 32'hDEAD_BEEF, 1));
        vec(1, 0, 1, 32'h8400_0004, 32'hDEAD_BEEF, mk(3'b010, 1, 1, 32'h8400_0004, 32'hDEAD_BEEF, 1));
        vec(1, 0, 1, 32'h8400_0004, 32'hDEAD_BEEF, mk(3'b000, 0, 1, 32'h8400_0004, 32'hDEAD_BEEF, 1));
        vec(1, 1, 1, 32'h8800_0000, 32'hDEAD_BEEF, mk(3'b000, 0, 1, 32'h8400_0004, 32'hDEAD_BEEF, 1));
        vec(1, 1, 1, 32'h8800_0004, 32'h11,       mk(3'b100, 0, 1, 32'h8800_0000, 32'h11,       0));
        vec(1, 0, 1, 32'h8800_0004, 32'h22,       mk(3'b100, 1, 1, 32'h8800_0000, 32'h11,       1));
        vec(1, 0, 1, 32'h8800_0004, 32'h22,       mk(3'b100, 0, 1, 32'h8800_0004, 32'h22,       1));
        vec(1, 0, 1, 32'h8800_0004, 32'h22,       mk(3'b100, 1, 1, 32'h8800_0004, 32'h22,       1));
        vec(1, 0, 1, 32'h8800_0004, 32'h22,       mk(3'b000, 0, 1, 32'h8800_0004, 32'h22,       1));
        vec(1, 1, 1, 32'h8000_0000, 32'h22,       mk(3'b000, 0, 1, 32'h8800_0004, 32'h22,       1));
        vec(1, 1, 0, 32'h8400_0008, 32'h55,       mk(3'b001, 0, 1, 32'h8000_0000, 32'h55,       0));
        vec(1, 0, 0, 32'h8400_0008, 32'h55,       mk(3'b001, 1, 1, 32'h8000_0000, 32'h55,       1));
        vec(1, 0, 0, 32'h8400_0008, 32'h55,       mk(3'b010, 0, 0, 32'h8400_0008, 32'h55,       0));
        vec(1, 0, 0, 32'h8400_0008, 32'h55,       mk(3'b010, 1, 0, 32'h8400_0008, 32'h55,       1));
        vec(1, 0, 0, 32'h8400_0008, 32'h55,       mk(3'b000, 0, 0, 32'h8400_0008, 32'h55,       1));
        vec(1, 1, 0, 32'h8800_0020, 32'h55,       mk(3'b100, 0, 0, 32'h8800_0020, 32'h55,       0));
        vec(1, 0, 0, 32'h8800_0020, 32'h55,       mk(3'b100, 1, 0, 32'h8800_0020, 32'h55,       1));
        vec(1, 1, 0, 32'h8000_0030, 32'h55,       mk(3'b001, 0, 0, 32'h8000_0030, 32'h55,       0));
        vec(1, 0, 0, 32'h8000_0030, 32'h55,       mk(3'b001, 1, 0, 32'h8000_0030, 32'h55,       1));
        vec(1, 1, 1, 32'h8400_0000, 32'h55,       mk(3'b000, 0, 0, 32'h8000_0030, 32'h55,       1));
        vec(1, 0, 1, 32'h8400_0000, 32'hA5A5_A5A5, mk(3'b010, 0, 1, 32'h8400_0000, 32'hA5A5_A5A5, 1));
        vec(1, 1, 1, 32'h8800_0008, 32'hA5A5_A5A5, mk(3'b010, 1, 1, 32'h8400_0000, 32'hA5A5_A5A5, 1));
        vec(1, 0, 1, 32'h8800_0008, 32'h77,       mk(3'b010, 0, 1, 32'h8400_0000, 32'h77,       1));
        vec(1, 0, 1, 32'h8800_0008, 32'h77,       mk(3'b010, 1, 1, 32'h8400_0000, 32'h77,       1));
        vec(1, 0, 1, 32'h8800_0008, 32'h77,       mk(3'b000, 0, 1, 32'h8400_0000, 32'h77,       1));

        @(posedge hclk);
        #1;
        foreach (vecs[i]) begin
            tick(vecs[i].rst_n, vecs[i].valid, vecs[i].hwrite, vecs[i].haddr, vecs[i].hwdata, 1'b1);
            check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
        end

        // Reset asserted for two cycles while a pipelined write is pending
        tick(1, 1, 1, 32'h8000_0000, 32'h0, 1);
        tick(1, 1, 1, 32'h8000_0004, 32'h1, 1);
        check("burst_writep", dut_out(), mk(3'b001, 0, 1, 32'h8000_0000, 32'h1, 0));
        tick(1, 0, 1, 32'h8000_0004, 32'h2, 1);
        check("burst_wenablep", dut_out(), mk(3'b001, 1, 1, 32'h8000_0000, 32'h1, 1));
        tick(0, 1, 1, 32'h8400_0000, 32'h3, 1);
        check("rst_mid_burst1", dut_out(), mk(3'b000, 0, 0, 32'h0, 32'h0, 1));
        tick(0, 1, 1, 32'h8400_0000, 32'h3, 1);
        check("rst_mid_burst2", dut_out(), mk(3'b000, 0, 0, 32'h0, 32'h0, 1));
        tick(1, 0, 0, 32'h8400_0000, 32'h0, 1);
        check("rst_release_idle", dut_out(), mk(3'b000, 0, 0, 32'h0, 32'h0, 1));

`ifdef APB_PREADY_EN
        // Read whose ENABLE phase is stretched by three Pready-low cycles
        tick(1, 1, 0, 32'h8000_0040, 32'h0, 1);
        check("rdy_setup", dut_out(), mk(3'b001, 0, 0, 32'h8000_0040, 32'h0, 0));
        tick(1, 0, 0, 32'h8000_0040, 32'h0, 1);
        check("rdy_enable", dut_out(), mk(3'b001, 1, 0, 32'h8000_0040, 32'h0, 1));
        for (int k = 0; k < 3; k++) begin
            tick(1, 0, 0, 32'h8000_0040, 32'h0, 0);
            check($sformatf("rdy_stall%0d", k), dut_out(), mk(3'b001, 1, 0, 32'h8000_0040, 32'h0, 0));
        end
        tick(1, 0, 0, 32'h8000_0040, 32'h0, 1);
        check("rdy_done", dut_out(), mk(3'b000, 0, 0, 32'h8000_0040, 32'h0, 1));
`endif

        // Random traffic against the reference model, plus protocol invariants
        tick(0, 0, 0, 32'h0, 32'h0, 1);
        check("rand_reset", dut_out(), m_out);
        prev = dut_out();
        for (int n = 0; n < 3000; n++) begin
            a = 32'h8000_0000 + 32'($urandom_range(0, 2)) * 32'h0400_0000 + ($urandom & 32'h03FF_FFFC);
            tick(($urandom_range(0, 59) != 0), ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                 a, $urandom, ($urandom_range(0, 3) != 0));
            check($sformatf("rand%0d", n), dut_out(), m_out);
            n_checks++;
            if ($countones(pselx) > 1) begin
                n_err++;
                $display("FAIL onehot%0d: got psel=%b expected zero or one-hot", n, pselx);
            end
            if (penable && !prev.pen && hresetn) begin
                n_checks++;
                if (prev.psel == 3'b000 || prev.psel !== pselx || prev.paddr !== paddr
                    || prev.pwrite !== pwrite || prev.pwdata !== pwdata) begin
                    n_err++;
                    $display("FAIL setup_match%0d: got {%s} expected equal to setup {%s}",
                             n, fmt(dut_out()), fmt(prev));
                end
            end
            prev = dut_out();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_fsm_controller.md
Name: apb_fsm_controller

Overview:
- APB-side initiator of the AHB-to-APB bridge.
- Consumes the pipelined address, data and control from the AHB slave interface (valid, Haddr/Haddr1/Haddr2, Hwdata, Hwrite/Hwritereg, tempselx).
- Sequences APB SETUP and ENABLE phases onto three peripheral selects.
- Drives Hreadyout back to AHB to insert wait states. Supports back-to-back and pipelined writes.

Parameters:
- ADDR_WIDTH, 32, width of Haddr* and Paddr.
- DATA_WIDTH, 32, width of Hwdata and Pwdata.

Ports:
- Hclk  in  1  bridge clock; all state and outputs update on its rising edge.
- Hresetn  in  1  synchronous, active-low reset, sampled on rising edge of Hclk.
- valid  in  1  current AHB beat is a legal NONSEQ/SEQ to the APB map with Hreadyin high.
- Haddr  in  ADDR_WIDTH  current AHB address.
- Haddr1  in  ADDR_WIDTH  Haddr delayed one cycle.
- Haddr2  in  ADDR_WIDTH  Haddr delayed two cycles.
- Hwdata  in  DATA_WIDTH  current AHB write data (data phase of previous address).
- Hwrite  in  1  direction of current address phase.
- Hwritereg  in  1  Hwrite delayed one cycle.
- tempselx  in  3  one-hot decode of Haddr: 001 = 0x8000_0000–0x83FF_FFFF, 010 = 0x8400_0000–0x87FF_FFFF, 100 = 0x8800_0000–0x8BFF_FFFF.
- Pselx  out  3  registered one-hot APB select.
- Penable  out  1  registered APB enable.
- Pwrite  out  1  registered APB direction.
- Paddr  out  ADDR_WIDTH  registered APB address.
- Pwdata  out  DATA_WIDTH  registered APB write data.
- Hreadyout  out  1  registered ready to AHB; 0 inserts a wait state.

Behaviour:
- Internal selx1/selx2: tempselx delayed 1 and 2 cycles, aligned with Haddr1/Haddr2. Cleared by reset.
- Reset (Hresetn=0 at edge):
  - state = IDLE.
  - Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hreadyout=1.
  - Applies from any state mid-transfer; no APB completion is attempted.
- All outputs are registered. Output values below are loaded on the edge that takes the named transition. Signals not listed hold their value.
- IDLE:
  - valid & ~Hwrite -> READ; load Paddr=Haddr, Pselx=tempselx, Pwrite=0, Penable=0, Hreadyout=0.
  - valid & Hwrite -> WWAIT; Pselx=0, Penable=0, Hreadyout=1.
  - else stay; Pselx=0, Penable=0, Hreadyout=1.
- WWAIT (data not yet present):
  - Always load Paddr=Haddr1, Pwdata=Hwdata, Pselx=selx1, Pwrite=1, Penable=0.
  - valid -> WRITEP with Hreadyout=0; ~valid -> WRITE with Hreadyout=1.
- READ -> RENABLE; Penable=1, Hreadyout=1.
- WRITE: Penable=1, Hreadyout=1; valid -> WENABLEP, else -> WENABLE.
- WRITEP -> WENABLEP; Penable=1, Hreadyout=1.
- RENABLE / WENABLE (transfer completes this cycle):
  - valid & ~Hwrite -> READ; load as IDLE->READ.
  - valid & Hwrite -> WWAIT; Pselx=0, Penable=0.
  - else -> IDLE; Pselx=0, Penable=0, Hreadyout=1.
- WENABLEP (a pipelined write is pending):
  - Hwritereg & valid -> WRITEP: Paddr=Haddr2, Pselx=selx2, Pwdata=Hwdata, Pwrite=1, Penable=0, Hreadyout=0.
  - Hwritereg & ~valid -> WRITE: same loads, Hreadyout=1.
  - ~Hwritereg -> READ: Paddr=Haddr1, Pselx=selx1, Pwrite=0, Penable=0, Hreadyout=0.
- Invariants (checked in verification):
  - Penable=1 only in the cycle after a SETUP cycle with identical Pselx/Paddr/Pwrite/Pwdata.
  - Pselx is zero or one-hot.
  - Pselx never changes while Penable=1.
  - Single read latency: valid read at edge N -> SETUP at N+1, ENABLE at N+2, Hreadyout=1 at N+2.

Optional Feature:
- Macro: APB_PREADY_EN.
- Defined:
  - Adds input Pready (1 bit).
  - In RENABLE, WENABLE and WENABLEP, if Pready=0: state holds, all P* outputs hold, Hreadyout=0.
  - Transitions above occur only when Pready=1.
- Undefined: no Pready port; every ENABLE phase lasts exactly one cycle.

Test Plan:
- Reset: hold Hresetn=0 for 2 cycles from WENABLEP mid-burst -> next edge Pselx=000, Penable=0, Paddr=0, Hreadyout=1, state IDLE.
- Single read at 0x8000_0010 -> SETUP: Pselx=001, Paddr=0x8000_0010, Pwrite=0, Penable=0, Hreadyout=0; next cycle Penable=1, Hreadyout=1; then IDLE with Pselx=000.
- Single write 0x8400_0004, data 0xDEAD_BEEF -> WWAIT, then Pselx=010, Paddr=0x8400_0004, Pwdata=0xDEAD_BEEF, Pwrite=1; then Penable=1; then IDLE.
- Back-to-back writes 0x8800_0000/0x11, 0x8800_0004/0x22 -> WWAIT->WRITEP->WENABLEP->WRITE->WENABLE. The two APB accesses appear in order with Pselx=100 and correct addr/data pairs; Hreadyout low only in WRITEP entry cycles.
- Write then read (0x8000_0000 write 0x55, 0x8400_0008 read) -> WENABLEP->READ; read SETUP shows Paddr=0x8400_0008, Pselx=010, Pwrite=0.
- APB_PREADY_EN defined, read with Pready=0 for 3 cycles -> Penable=1 and Paddr stable for 4 cycles, Hreadyout=0 for 3, then 1.
